dynamic_branch_predictor: RTL and testbench
===========================================

# dynamic_branch_predictor

Parametrised fetch-stage branch predictor that replaces the static always-taken scheme with a direct-mapped table of 2-bit saturating counters indexed by PC. It predicts B-type instructions in Fetch, resolves them in Execute, and corrects mispredictions in both directions: predicted-taken/not-taken, and predicted-not-taken/taken. It sits between the instruction memory read port and the PC-select mux, and drives the same redirect and flush signals consumed by the hazard unit.

## Interface
Parameters:
- DATA_WIDTH, 32, PC/instruction width
- INDEX_BITS, 6, table index width; table depth = 2**INDEX_BITS entries
- CNT_RESET, 2'b01, counter value loaded on reset (weakly not-taken)
- STAT_WIDTH, 32, width of the performance counters

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- RD  in  DATA_WIDTH  instruction word in Fetch
- PCF  in  DATA_WIDTH  PC of the Fetch instruction
- BranchE  in  1  Execute stage holds a conditional branch
- TakenE  in  1  resolved branch outcome in Execute
- JumpE  in  1  Execute stage holds JAL/JALR
- PCE  in  DATA_WIDTH  PC of the Execute instruction
- TargetE  in  DATA_WIDTH  resolved branch target in Execute
- PredTakenE  in  1  PredTakenF of this branch, piped to Execute by the pipeline registers
- PredTakenF  out  1  Fetch prediction, to be piped down
- PCBPU  out  DATA_WIDTH  redirect PC
- PCBPUSrc  out  1  select PCBPU as next PC
- flushBranch  out  1  flush Decode and Execute registers (misprediction)
- BranchCount  out  STAT_WIDTH  resolved conditional branches
- MispredCount  out  STAT_WIDTH  mispredicted conditional branches

## Operation
- Fetch decode: IsBranchF = (RD[6:0] == 7'b1100011). immB = sign-extended {RD[31], RD[7], RD[30:25], RD[11:8], 1'b0}. TargetF = PCF + immB, with wrap-around modulo 2**DATA_WIDTH.
- Index: idxF = PCF[INDEX_BITS+1:2]; idxE = PCE[INDEX_BITS+1:2]. No tags, so aliasing is accepted.
- Prediction: PredTakenF = IsBranchF & cnt[idxF][1] & ~JumpE. The read is combinational.
- Resolution, only when BranchE & ~JumpE:
  - MispredE = PredTakenE ^ TakenE.
  - Predicted taken, not taken: redirect to PCE + 4.
  - Predicted not taken, taken: redirect to TargetE.
- Output priority for PCBPU/PCBPUSrc:
  - 1st: MispredE gives PCBPUSrc = 1, flushBranch = 1, PCBPU = correction PC.
  - 2nd: PredTakenF gives PCBPUSrc = 1, PCBPU = TargetF.
  - Else PCBPUSrc = 0, PCBPU = 0.
- JumpE high: no prediction, no resolution, no table or stat update. The jump redirect is owned elsewhere.
- Counter update at the clock edge when BranchE & ~JumpE:
  - TakenE increments cnt[idxE], saturating at 2'b11.
  - ~TakenE decrements cnt[idxE], saturating at 2'b00.
- Same-cycle read and update of the same index: Fetch sees the pre-update value. There is no bypass.
- Stats:
  - BranchCount += 1 on each resolution.
  - MispredCount += 1 on each MispredE.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (asynchronous, immediate): every counter = CNT_RESET; BranchCount = MispredCount = 0. The combinational outputs follow their inputs, so PredTakenF = 0 because CNT_RESET[1] = 0.
- Reset asserted mid-update: the table write is lost and the reset value wins.
- Prediction latency 0 cycles: redirect is applied at the next PCF edge.
- Resolution: 2 cycles after Fetch. The flush and the correction redirect are in the same cycle as BranchE.
- Counter state after an update is visible to Fetch from the cycle following the edge.
- Stats are registered: values update one cycle after the resolving cycle.

## Structure
- Package bpu_pkg holds:
  - typedef enum logic [1:0] {SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11} bht_cnt_t
  - localparam OP_BRANCH = 7'b1100011
  - functions sat_inc and sat_dec
- One sub-module: bpu_bht. It holds the counter array, has a combinational read port (idxF) and a synchronous write port (idxE, taken, en), and takes the asynchronous reset.
- Top level contains the decode, target adder, redirect priority mux and stat counters.

## Test plan
1. Reset, then a BEQ at PCF=0x100 with imm=+16: PredTakenF=0, PCBPUSrc=0.
2. Resolve the 0x100 branch TakenE=1 twice (PredTakenE=0): cycle 1 gives flushBranch=1, PCBPU=TargetE=0x110. Counter goes 01→10→11. The next fetch of 0x100 gives PredTakenF=1, PCBPU=0x110.
3. Counter at ST, PredTakenE=1, TakenE=0 at PCE=0x100: flushBranch=1, PCBPU=0x104, counter 11→10, MispredCount +1. A second not-taken resolution gives counter 01, and the following fetch gives PredTakenF=0.
4. Mispredict in Execute while a predicted-taken branch is in Fetch in the same cycle: PCBPU = correction PC (0x104), not TargetF.
5. Aliasing and bypass: PCF=0x200 and PCE=0x100 map to the same index (INDEX_BITS=6), with an update in the same cycle. Fetch uses the old counter and the new value appears the next cycle. JumpE=1 with BranchE=1 produces no update, no flush and no stat change.
6. Stats saturation with STAT_WIDTH=4: 20 resolutions give BranchCount=4'hF. Asserting rst mid-stream immediately zeroes both counters and restores every table entry to 01.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared types and helpers for the dynamic branch predictor: 2-bit counter states,
// the B-type opcode and saturating counter arithmetic.
package bpu_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_cnt_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic bht_cnt_t sat_inc(input bht_cnt_t c);
        return (c == ST) ? ST : bht_cnt_t'(c + 2'b01);
    endfunction

    function automatic bht_cnt_t sat_dec(input bht_cnt_t c);
        return (c == SNT) ? SNT : bht_cnt_t'(c - 2'b01);
    endfunction

endpackage

// File: rtl/bpu_bht.sv
// Direct-mapped table of 2-bit saturating counters: combinational read for Fetch,
// clocked update from Execute. No read/write bypass, so Fetch sees the pre-update value.
module bpu_bht
    import bpu_pkg::*;
#(
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] CNT_RESET  = 2'b01
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output bht_cnt_t              rd_cnt,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_taken,
    input  logic                  wr_en
);

    localparam int DEPTH = 2 ** INDEX_BITS;

    bht_cnt_t cnt_tbl [DEPTH];

    assign rd_cnt = cnt_tbl[rd_idx];

    // Reset wins over a concurrent write, so an in-flight update is discarded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_tbl[i] <= bht_cnt_t'(CNT_RESET);
            end
        end else if (wr_en) begin
            cnt_tbl[wr_idx] <= wr_taken ? sat_inc(cnt_tbl[wr_idx]) : sat_dec(cnt_tbl[wr_idx]);
        end
    end

endmodule

// File: rtl/dynamic_branch_predictor.sv
// Fetch-stage branch predictor: predicts B-type instructions from the counter table,
// resolves them in Execute and redirects/flushes on a misprediction in either direction.
module dynamic_branch_predictor
    import bpu_pkg::*;
#(
    parameter int         DATA_WIDTH = 32,
    parameter int         INDEX_BITS = 6,
    parameter logic [1:0] CNT_RESET  = 2'b01,
    parameter int         STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] RD,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic                  BranchE,
    input  logic                  TakenE,
    input  logic                  JumpE,
    input  logic [DATA_WIDTH-1:0] PCE,
    input  logic [DATA_WIDTH-1:0] TargetE,
    input  logic                  PredTakenE,
    output logic                  PredTakenF,
    output logic [DATA_WIDTH-1:0] PCBPU,
    output logic                  PCBPUSrc,
    output logic                  flushBranch,
    output logic [STAT_WIDTH-1:0] BranchCount,
    output logic [STAT_WIDTH-1:0] MispredCount
);

    localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

    logic                  isbranch_f;
    logic [DATA_WIDTH-1:0] imm_b;
    logic [DATA_WIDTH-1:0] target_f;
    logic [INDEX_BITS-1:0] idx_f;
    logic [INDEX_BITS-1:0] idx_e;
    bht_cnt_t              cnt_f;
    logic                  resolve_e;
    logic                  mispred_e;
    logic [DATA_WIDTH-1:0] correct_pc;

    assign isbranch_f = (RD[6:0] == OP_BRANCH);
    assign imm_b      = {{(DATA_WIDTH-13){RD[31]}}, RD[31], RD[7], RD[30:25], RD[11:8], 1'b0};
    assign target_f   = PCF + imm_b;

    assign idx_f = PCF[INDEX_BITS+1:2];
    assign idx_e = PCE[INDEX_BITS+1:2];

    // A jump in Execute suppresses both prediction and resolution; its redirect lives elsewhere.
    assign resolve_e  = BranchE & ~JumpE;
    assign mispred_e  = resolve_e & (PredTakenE ^ TakenE);
    assign correct_pc = PredTakenE ? (PCE + PC_STEP) : TargetE;

    assign PredTakenF = isbranch_f & cnt_f[1] & ~JumpE;

    bpu_bht #(
        .INDEX_BITS(INDEX_BITS),
        .CNT_RESET (CNT_RESET)
    ) u_bht (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (idx_f),
        .rd_cnt  (cnt_f),
        .wr_idx  (idx_e),
        .wr_taken(TakenE),
        .wr_en   (resolve_e)
    );

    // Correcting an older mispredicted branch outranks steering the younger Fetch instruction.
    always_comb begin
        PCBPU       = '0;
        PCBPUSrc    = 1'b0;
        flushBranch = 1'b0;
        if (mispred_e) begin
            PCBPU       = correct_pc;
            PCBPUSrc    = 1'b1;
            flushBranch = 1'b1;
        end else if (PredTakenF) begin
            PCBPU    = target_f;
            PCBPUSrc = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            BranchCount  <= '0;
            MispredCount <= '0;
        end else if (resolve_e) begin
            if (BranchCount != '1) begin
                BranchCount <= BranchCount + 1'b1;
            end
            if (mispred_e && (MispredCount != '1)) begin
                MispredCount <= MispredCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dynamic_branch_predictor.sv
// Scoreboard bench for dynamic_branch_predictor: directed scenarios then random traffic,
// all checked against an integer-arithmetic reference model of the counter table and stats.
module tb_dynamic_branch_predictor;

    localparam int DW = 32;
    localparam int IB = 6;
    localparam int SW = 4;
    localparam int STAT_MAX = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] RD = '0;
    logic [DW-1:0] PCF = '0;
    logic          BranchE = 1'b0;
    logic          TakenE = 1'b0;
    logic          JumpE = 1'b0;
    logic [DW-1:0] PCE = '0;
    logic [DW-1:0] TargetE = '0;
    logic          PredTakenE = 1'b0;
    logic          PredTakenF;
    logic [DW-1:0] PCBPU;
    logic          PCBPUSrc;
    logic          flushBranch;
    logic [SW-1:0] BranchCount;
    logic [SW-1:0] MispredCount;

    dynamic_branch_predictor #(
        .DATA_WIDTH(DW),
        .INDEX_BITS(IB),
        .CNT_RESET (2'b01),
        .STAT_WIDTH(SW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .RD          (RD),
        .PCF         (PCF),
        .BranchE     (BranchE),
        .TakenE      (TakenE),
        .JumpE       (JumpE),
        .PCE         (PCE),
        .TargetE     (TargetE),
        .PredTakenE  (PredTakenE),
        .PredTakenF  (PredTakenF),
        .PCBPU       (PCBPU),
        .PCBPUSrc    (PCBPUSrc),
        .flushBranch (flushBranch),
        .BranchCount (BranchCount),
        .MispredCount(MispredCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          pred;
        logic          src;
        logic [DW-1:0] pc;
        logic          flush;
        int            bcnt;
        int            mcnt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    int model_cnt [64];
    int model_bcnt;
    int model_mcnt;

    localparam logic [DW-1:0] BEQ_P16 = 32'h0000_0863;
    localparam logic [DW-1:0] NOP     = 32'h0000_0013;

    function automatic void modelReset();
        for (int i = 0; i < 64; i++) model_cnt[i] = 1;
        model_bcnt = 0;
        model_mcnt = 0;
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs, pushes the model's expectation, then advances the model past the edge.
    task automatic applyStimulus(input logic [DW-1:0] rd, input logic [DW-1:0] pcf,
                                 input logic br, input logic tk, input logic jmp, input logic pte,
                                 input logic [DW-1:0] pce, input logic [DW-1:0] tgte);
        exp_t          e;
        logic [12:0]   b13;
        int            imm;
        int            fidx, eidx;
        logic          is_br, resolve, mis;
        @(posedge clk);
        #1;
        RD = rd; PCF = pcf; BranchE = br; TakenE = tk; JumpE = jmp;
        PredTakenE = pte; PCE = pce; TargetE = tgte;

        b13   = {rd[31], rd[7], rd[30:25], rd[11:8], 1'b0};
        imm   = b13[12] ? int'(b13) - 8192 : int'(b13);
        fidx  = (pcf / 4) % 64;
        eidx  = (pce / 4) % 64;
        is_br = (rd[6:0] == 7'b1100011);
        resolve = br && !jmp;
        mis     = resolve && (pte != tk);

        e.pred  = is_br && (model_cnt[fidx] >= 2) && !jmp;
        e.flush = mis;
        e.src   = mis || e.pred;
        e.pc    = mis ? (pte ? pce + 32'd4 : tgte) : (e.pred ? pcf + DW'(imm) : '0);
        e.bcnt  = model_bcnt;
        e.mcnt  = model_mcnt;
        sb_q.push_back(e);

        if (resolve) begin
            model_cnt[eidx] = tk ? ((model_cnt[eidx] == 3) ? 3 : model_cnt[eidx] + 1)
                                 : ((model_cnt[eidx] == 0) ? 0 : model_cnt[eidx] - 1);
            if (model_bcnt < STAT_MAX) model_bcnt++;
            if (mis && model_mcnt < STAT_MAX) model_mcnt++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            checkOutput("PredTakenF", DW'(PredTakenF), DW'(e.pred));
            checkOutput("PCBPUSrc", DW'(PCBPUSrc), DW'(e.src));
            checkOutput("PCBPU", PCBPU, e.pc);
            checkOutput("flushBranch", DW'(flushBranch), DW'(e.flush));
            checkOutput("BranchCount", DW'(BranchCount), DW'(e.bcnt));
            checkOutput("MispredCount", DW'(MispredCount), DW'(e.mcnt));
        end
    end

    task automatic randomCycle();
        logic [DW-1:0] rd;
        logic [DW-1:0] pcf, pce;
        rd = $urandom;
        if ($urandom_range(0, 1) == 1) rd[6:0] = 7'b1100011;
        else if (rd[6:0] == 7'b1100011) rd[0] = 1'b0;
        pcf = (DW'($urandom_range(0, 3)) << 8) | (DW'($urandom_range(0, 7)) << 2);
        pce = (DW'($urandom_range(0, 3)) << 8) | (DW'($urandom_range(0, 7)) << 2);
        applyStimulus(rd, pcf, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), pce, $urandom);
    endtask

    // Reset lands while an update is being presented; the write must be lost and state cleared at once.
    task automatic pulseReset();
        @(posedge clk);
        #1;
        RD = BEQ_P16; PCF = 32'h100; BranchE = 1'b1; TakenE = 1'b1; JumpE = 1'b0;
        PredTakenE = 1'b1; PCE = 32'h100; TargetE = 32'h110;
        #1 rst = 1'b1;
        #1;
        checkOutput("rst_BranchCount", DW'(BranchCount), '0);
        checkOutput("rst_MispredCount", DW'(MispredCount), '0);
        checkOutput("rst_PredTakenF", DW'(PredTakenF), '0);
        @(posedge clk);
        #1;
        BranchE = 1'b0;
        rst = 1'b0;
        modelReset();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        modelReset();
        #12;
        checkOutput("reset_BranchCount", DW'(BranchCount), '0);
        checkOutput("reset_MispredCount", DW'(MispredCount), '0);
        rst = 1'b0;

        applyStimulus(BEQ_P16, 32'h100, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(NOP, 32'h104, 1, 1, 0, 0, 32'h100, 32'h110);
        applyStimulus(NOP, 32'h108, 1, 1, 0, 0, 32'h100, 32'h110);
        applyStimulus(BEQ_P16, 32'h100, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(NOP, 32'h104, 1, 0, 0, 1, 32'h100, 32'h110);
        applyStimulus(NOP, 32'h108, 1, 0, 0, 0, 32'h100, 32'h110);
        applyStimulus(BEQ_P16, 32'h100, 0, 0, 0, 0, 32'h0, 32'h0);

        applyStimulus(NOP, 32'h10c, 1, 1, 0, 0, 32'h140, 32'h150);
        applyStimulus(NOP, 32'h10c, 1, 1, 0, 0, 32'h140, 32'h150);
        applyStimulus(BEQ_P16, 32'h140, 1, 0, 0, 1, 32'h100, 32'h110);

        applyStimulus(NOP, 32'h10c, 1, 1, 0, 0, 32'h100, 32'h110);
        applyStimulus(BEQ_P16, 32'h200, 1, 1, 0, 1, 32'h100, 32'h110);
        applyStimulus(BEQ_P16, 32'h200, 0, 0, 0, 0, 32'h0, 32'h0);
        applyStimulus(BEQ_P16, 32'h200, 1, 0, 1, 1, 32'h100, 32'h110);
        applyStimulus(BEQ_P16, 32'h200, 0, 0, 0, 0, 32'h0, 32'h0);

        for (int i = 0; i < 300; i++) randomCycle();
        pulseReset();
        applyStimulus(BEQ_P16, 32'h100, 0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 150; i++) randomCycle();

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
